// File: rtl/uart_msg_framer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module     : uart_msg_framer_pkg                                        |
// | Description: Shared frame constants and state encodings for the UART    |
// |              message framer and its byte handshake sub-module.          |
// | Revision   : 1.0 - initial release                                      |
// ---------------------------------------------------------------------------
package uart_msg_framer_pkg;

  // Special frame bytes; the RX decoder uses the same values
  localparam logic [7:0] SP_SYNC = 8'h7E;
  localparam logic [7:0] SP_ESC  = 8'hFE;
  localparam logic [7:0] SP_END  = 8'h03;

  // Frame-level sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_BCNT  = 3'd2,
    ST_BODY  = 3'd3,
    ST_TAIL  = 3'd4,
    ST_DRAIN = 3'd5
  } frame_state_e;

  // Per-byte uart handshake phases; LOAD is the cycle ld_tx_data is high
  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETTLE = 2'd1,
    PH_WAIT   = 2'd2
  } tx_phase_e;

  // Bytes that would be mistaken for frame control by the receiver
  function automatic logic needs_escape(input logic [7:0] b);
    return (b == SP_SYNC) || (b == SP_ESC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_msg_framer_tx_byte_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module     : uart_msg_framer_tx_byte_if                                 |
// | Description: Hands one byte at a time to the uart transmitter, inserting|
// |              an escape byte when requested, with LOAD/SETTLE/WAIT       |
// |              handshake on tx_empty.                                     |
// | Revision   : 1.0 - initial release                                      |
// ---------------------------------------------------------------------------
module uart_msg_framer_tx_byte_if
  import uart_msg_framer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,       // asynchronous, active-low
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_stuff,  // byte may be escaped
  input  logic       tx_empty,
  output logic [7:0] tx_data,
  output logic       ld_tx_data,
  output logic       byte_done,   // data byte (not the ESC) handed to uart
  output logic       tx_idle      // no handshake outstanding, uart drained
);

  tx_phase_e  phase_q, phase_d;
  logic       esc_q, esc_d;       // ESC already sent for the current byte
  logic [7:0] data_q, data_d;     // last byte handed to uart
  logic       can_load;
  logic       need_esc;
  logic [7:0] load_byte;

  // Handshake phase sequencing and escape insertion
  always_comb begin
    phase_d   = phase_q;
    esc_d     = esc_q;
    data_d    = data_q;
    can_load  = tx_empty && byte_valid &&
                ((phase_q == PH_IDLE) || (phase_q == PH_WAIT));
    need_esc  = byte_stuff && needs_escape(byte_in) && !esc_q;
    load_byte = need_esc ? SP_ESC : byte_in;
    if (can_load) begin
      phase_d = PH_SETTLE;
      data_d  = load_byte;
      esc_d   = need_esc;
    end else begin
      case (phase_q)
        PH_SETTLE: phase_d = PH_WAIT;          // uart empty flag lags the load
        PH_WAIT:   if (tx_empty) phase_d = PH_IDLE;
        default:   phase_d = phase_q;
      endcase
    end
  end

  // Outputs: the loaded byte appears in the LOAD cycle and is then held
  always_comb begin
    ld_tx_data = can_load;
    byte_done  = can_load && !need_esc;
    tx_data    = can_load ? load_byte : data_q;
    tx_idle    = (phase_q == PH_IDLE);
  end

  // Handshake state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_IDLE;
      esc_q   <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      phase_q <= phase_d;
      esc_q   <= esc_d;
      data_q  <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_msg_framer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module     : uart_msg_framer                                            |
// | Description: Frames a parallel message as SYNC, BCNT, BODY, END with    |
// |              byte stuffing and feeds it byte-by-byte to a uart tx port. |
// | Revision   : 1.0 - initial release                                      |
// ---------------------------------------------------------------------------
module uart_msg_framer
  import uart_msg_framer_pkg::*;
#(
  parameter int MAXBYTES = 10
) (
  input  logic                  clk,
  input  logic                  reset,      // asynchronous, active-low
  input  logic [8*MAXBYTES-1:0] msg_data,
  input  logic [7:0]            msg_len,
  input  logic                  msg_valid,
  output logic                  msg_ready,
  output logic [7:0]            tx_data,
  output logic                  ld_tx_data,
  output logic                  tx_enable,
  input  logic                  tx_empty,
  output logic                  frame_done,
  output logic                  len_err
);

  frame_state_e          state_q, state_d;
  logic [8*MAXBYTES-1:0] data_q, data_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            idx_q, idx_d;
  logic                  frame_done_q, frame_done_d;
  logic                  len_err_q, len_err_d;

  logic                  len_ok;
  logic [7:0]            body_byte;
  logic [7:0]            byte_sel;
  logic                  byte_valid;
  logic                  byte_stuff;
  logic                  byte_done;
  logic                  tx_idle;

  // Select the byte the current frame state wants on the wire
  always_comb begin
    body_byte = 8'h00;
    for (int k = 0; k < MAXBYTES; k++) begin
      if (idx_q == 8'(k)) body_byte = data_q[8*k +: 8];
    end
    byte_valid = 1'b1;
    byte_stuff = 1'b0;
    case (state_q)
      ST_SYNC: byte_sel = SP_SYNC;
      ST_BCNT: begin byte_sel = len_q;     byte_stuff = 1'b1; end
      ST_BODY: begin byte_sel = body_byte; byte_stuff = 1'b1; end
      ST_TAIL: byte_sel = SP_END;
      default: begin byte_sel = 8'h00;     byte_valid = 1'b0; end
    endcase
  end

  // Frame sequencing: advance only when a data byte has been handed over
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    len_d        = len_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    len_err_d    = 1'b0;
    len_ok       = (msg_len != 8'd0) && (msg_len <= 8'(MAXBYTES));
    case (state_q)
      ST_IDLE: begin
        if (msg_valid) begin
          if (len_ok) begin
            data_d  = msg_data;
            len_d   = msg_len;
            idx_d   = 8'd0;
            state_d = ST_SYNC;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      ST_SYNC: if (byte_done) state_d = ST_BCNT;
      ST_BCNT: if (byte_done) state_d = ST_BODY;
      ST_BODY: begin
        if (byte_done) begin
          if (idx_q == len_q - 8'd1) state_d = ST_TAIL;
          else                       idx_d   = idx_q + 8'd1;
        end
      end
      ST_TAIL: if (byte_done) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (tx_idle) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      len_q        <= 8'd0;
      idx_q        <= 8'd0;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
      len_err_q    <= len_err_d;
    end
  end

  uart_msg_framer_tx_byte_if u_tx_byte_if (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_sel),
    .byte_valid (byte_valid),
    .byte_stuff (byte_stuff),
    .tx_empty   (tx_empty),
    .tx_data    (tx_data),
    .ld_tx_data (ld_tx_data),
    .byte_done  (byte_done),
    .tx_idle    (tx_idle)
  );

  // Status outputs derived from the frame state
  always_comb begin
    msg_ready  = (state_q == ST_IDLE);
    tx_enable  = (state_q != ST_IDLE);
    frame_done = frame_done_q;
    len_err    = len_err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_msg_framer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module     : tb_uart_msg_framer                                         |
// | Description: Directed self-checking bench for uart_msg_framer with a    |
// |              simple uart holding-register model.                        |
// | Revision   : 1.0 - initial release                                      |
// ---------------------------------------------------------------------------
module tb_uart_msg_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic [79:0] msg_data;
  logic [7:0]  msg_len;
  logic        msg_valid;
  logic        msg_ready;
  logic [7:0]  tx_data;
  logic        ld_tx_data;
  logic        tx_enable;
  logic        tx_empty;
  logic        frame_done;
  logic        len_err;

  int          errors = 0;
  int          checks = 0;

  // uart model state
  int          hold = 1;
  int          busy;
  logic [7:0]  cap [0:255];
  int          ld_count = 0;
  int          fd_count = 0;
  int          ld_viol = 0;
  int          stab_viol = 0;
  logic [7:0]  last_tx;

  always #5 clk = ~clk;

  uart_msg_framer #(.MAXBYTES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .msg_data   (msg_data),
    .msg_len    (msg_len),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .tx_data    (tx_data),
    .ld_tx_data (ld_tx_data),
    .tx_enable  (tx_enable),
    .tx_empty   (tx_empty),
    .frame_done (frame_done),
    .len_err    (len_err)
  );

  // uart holding register: goes busy for 'hold' cycles after each load
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_empty <= 1'b1;
      busy     <= 0;
    end else if (ld_tx_data) begin
      tx_empty <= 1'b0;
      busy     <= hold;
    end else if (busy != 0) begin
      busy <= busy - 1;
      if (busy == 1) tx_empty <= 1'b1;
    end
  end

  // Capture loaded bytes and protocol violations
  always @(posedge clk) begin
    if (ld_tx_data) begin
      cap[ld_count[7:0]] <= tx_data;
      ld_count <= ld_count + 1;
      if (!tx_empty) ld_viol <= ld_viol + 1;
    end
    if (frame_done) fd_count <= fd_count + 1;
  end

  // tx_data must only change on a load
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_tx <= 8'h00;
    end else begin
      if (!ld_tx_data && tx_data !== last_tx) stab_viol <= stab_viol + 1;
      if (ld_tx_data) last_tx <= tx_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] len, input logic [79:0] data);
    @(negedge clk);
    msg_len   = len;
    msg_data  = data;
    msg_valid = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
  endtask

  task automatic wait_frame(input int target);
    for (int i = 0; i < 3000 && fd_count < target; i++) @(negedge clk);
    chk("frame_timeout", 32'(fd_count >= target), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // exp holds expected byte i at [8i+7:8i]
  task automatic chk_seq(input string tag, input int base, input int n, input logic [127:0] exp);
    chk({tag, "_count"}, 32'(ld_count - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, cap[8'(base + i)]}, {24'd0, exp[8*i +: 8]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int fd0;
    reset     = 1'b0;
    msg_data  = '0;
    msg_len   = 8'd0;
    msg_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_msg_ready",  32'(msg_ready),  32'd1);
    chk("rst_tx_data",    32'(tx_data),    32'd0);
    chk("rst_ld_tx_data", 32'(ld_tx_data), 32'd0);
    chk("rst_tx_enable",  32'(tx_enable),  32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_len_err",    32'(len_err),    32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Plain two-byte frame: 7E 02 11 22 03
    base = ld_count; fd0 = fd_count;
    send(8'd2, 80'h2211);
    chk("f1_busy_ready", 32'(msg_ready), 32'd0);
    chk("f1_busy_enable", 32'(tx_enable), 32'd1);
    wait_frame(fd0 + 1);
    chk_seq("f1", base, 5, 128'h03_22_11_02_7E);
    chk("f1_done_count", 32'(fd_count - fd0), 32'd1);
    chk("f1_ready", 32'(msg_ready), 32'd1);
    chk("f1_enable_off", 32'(tx_enable), 32'd0);

    // Escaped body: 7E 03 FE 7E FE FE 05 03
    base = ld_count; fd0 = fd_count;
    send(8'd3, 80'h05FE7E);
    wait_frame(fd0 + 1);
    chk_seq("f2", base, 8, 128'h03_05_FE_FE_7E_FE_03_7E);
    chk("f2_done_count", 32'(fd_count - fd0), 32'd1);

    // Rejected lengths: 0 and MAXBYTES+1
    base = ld_count;
    send(8'd0, 80'h1);
    chk("len0_err", 32'(len_err), 32'd1);
    chk("len0_ready", 32'(msg_ready), 32'd1);
    @(negedge clk);
    chk("len0_err_pulse", 32'(len_err), 32'd0);
    send(8'd11, 80'h1);
    chk("len11_err", 32'(len_err), 32'd1);
    chk("len11_ready", 32'(msg_ready), 32'd1);
    @(negedge clk);
    chk("len11_err_pulse", 32'(len_err), 32'd0);
    repeat (5) @(negedge clk);
    chk("len_no_load", 32'(ld_count - base), 32'd0);
    chk("len_ready_idle", 32'(msg_ready), 32'd1);

    // Slow uart; request and data changes mid-frame ignored
    hold = 20;
    base = ld_count; fd0 = fd_count;
    send(8'd2, 80'hA55A);
    repeat (10) @(negedge clk);
    chk("slow_single_load", 32'(ld_count - base), 32'd1);
    msg_data  = 80'h3333;
    msg_len   = 8'd1;
    msg_valid = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    wait_frame(fd0 + 1);
    chk_seq("slow", base, 5, 128'h03_A5_5A_02_7E);
    chk("slow_done_count", 32'(fd_count - fd0), 32'd1);
    chk("ld_while_busy", 32'(ld_viol), 32'd0);
    chk("tx_data_stable", 32'(stab_viol), 32'd0);
    hold = 1;

    // Reset after the third byte of a maximum-length frame
    base = ld_count;
    send(8'd10, 80'h0A090807060504030201);
    for (int i = 0; i < 500 && ld_count < base + 3; i++) @(negedge clk);
    chk("mid_reach3", 32'(ld_count >= base + 3), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_msg_ready",  32'(msg_ready),  32'd1);
    chk("mid_tx_data",    32'(tx_data),    32'd0);
    chk("mid_ld_tx_data", 32'(ld_tx_data), 32'd0);
    chk("mid_tx_enable",  32'(tx_enable),  32'd0);
    chk("mid_frame_done", 32'(frame_done), 32'd0);
    chk("mid_len_err",    32'(len_err),    32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    base = ld_count; fd0 = fd_count;
    send(8'd1, 80'h42);
    wait_frame(fd0 + 1);
    chk_seq("post", base, 4, 128'h03_42_01_7E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
